icache_prefetch_gen: RTL
========================

# icache_prefetch_gen

Next-line instruction prefetch generator feeding the prefetch input of the icache tag-request arbiter. It observes accepted demand fetches (upstream request handshakes at the arbiter) and generates up to PF_DEPTH sequential line-address requests ahead of each new demand line. Requests stay inside the demand line's 4 KB page. They are buffered in a small FIFO and presented on the arbiter's lowest-priority prefetch port. Line deduplication against the last generated line means a sequential fetch stream costs one prefetch per new line.

## Interface
- LINE_OFFSET, 6, log2 of line size in bytes (64 B lines)
- PF_DEPTH, 2, maximum lines generated ahead of a trigger line (1..8)
- FIFO_DEPTH, 4, prefetch request buffer entries (power of two, ≥2)
- clk  in  1  clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- upstream_rxreq_vld  in  1  demand request valid at arbiter
- upstream_rxreq_rdy  in  1  arbiter accepted demand; trigger = vld & rdy
- upstream_rxreq_pld  in  pc_req_t  demand payload: 32-bit address, then two 5-bit fields
- pf_enable  in  1  prefetch enable; level
- pf_flush  in  1  single-cycle pulse; discards all pending work (redirect/invalidate)
- prefetch_req_vld  out  1  FIFO head valid
- prefetch_req_rdy  in  1  arbiter accepts head
- prefetch_req_pld  out  pc_req_t  FIFO head payload

## Operation
- Trigger line: L = addr[31:LINE_OFFSET]. Arithmetic is modulo 2^(32-LINE_OFFSET).
- State register last_pushed (line number plus valid bit) holds the last line written into the FIFO.
- FSM with two states, IDLE and GEN. Registers: next_line, remaining (count), page (addr[31:12] of the trigger), and the two 5-bit fields.
- On a trigger with pf_enable=1, compute d = last_pushed − L.
  - If last_pushed is valid and 1 ≤ d ≤ PF_DEPTH: next_line = last_pushed+1, remaining = PF_DEPTH−d.
  - Otherwise: next_line = L+1, remaining = PF_DEPTH.
  - If remaining = 0, go to IDLE. Otherwise go to GEN.
  - The two 5-bit fields are copied from the trigger payload.
- A trigger arriving in GEN overrides any generation in progress and is evaluated as above.
- GEN, each cycle:
  - If next_line's page ≠ page: go to IDLE, nothing pushed (page-cross stop; this also covers wrap past 0xFFFFFFFF).
  - Else if FIFO is not full: push {next_line, LINE_OFFSET'b0, fields}, set last_pushed = next_line, increment next_line, decrement remaining. Go to IDLE when remaining reaches 0.
  - Else, FIFO full: stall in GEN, with no push and no state change.
- A push and a trigger in the same cycle: the push completes, and the trigger's d is computed using the updated last_pushed.
- A full FIFO blocks the push even if a pop happens in the same cycle (full is registered; no bypass).
- pf_enable=0: triggers are ignored. GEN goes to IDLE on the next edge. The FIFO keeps draining.
- pf_flush:
  - FIFO is emptied, FSM goes to IDLE, last_pushed is invalidated.
  - Flush wins over a same-cycle trigger, push and pop. The pop is not counted; the arbiter must ignore a handshake in the flush cycle.
- Output: prefetch_req_vld = FIFO not empty, prefetch_req_pld = FIFO head, both registered. The head is popped on vld & rdy.
- The payload stays stable while vld=1 and rdy=0.

## Timing
- Reset values:
  - prefetch_req_vld=0 and prefetch_req_pld=0.
  - FIFO empty, FSM in IDLE, last_pushed invalid, remaining=0.
- Trigger accepted in cycle T → GEN in T+1 → first push at the end of T+1 → prefetch_req_vld=1 in T+2.
- Sustained rate is one push per cycle while GEN and not full, and one pop per cycle.
- Flush in cycle T → prefetch_req_vld=0 in T+1.
- Asserting rst_n low mid-generation or mid-drain forces the reset values asynchronously. No request is emitted after reset until a new trigger.

## Test plan
- Single trigger at addr 0x0000_1000, rdy=1 → prefetch addrs 0x1040 and then 0x1080, in cycles T+2 and T+3; the 5-bit fields match the trigger.
- Sequential triggers at 0x1000, then 0x1040, then 0x1080 → pushes are 0x1040, 0x1080, then 0x10C0, then 0x1100. No duplicate line is pushed.
- Trigger at 0x0000_1F80 → only 0x1FC0 is pushed; 0x2000 is suppressed (page cross). Trigger at 0xFFFF_FFC0 → nothing is pushed.
- rdy=0 held, with triggers at 0x1000, 0x3000, 0x5000 → FIFO fills at 4 entries and the generator stalls in GEN. Payload is held stable. After rdy goes to 1, the remaining 0x5080 is pushed and all 5 requests drain in order.
- pf_flush pulsed in GEN while the FIFO holds 3 entries, with a same-cycle trigger → vld=0 next cycle and no requests follow. A new trigger at 0x1000 then yields 0x1040 (last_pushed was cleared).
- rst_n asserted low while 2 entries are pending → vld drops asynchronously. After release, with no trigger, vld stays 0.

Source files
------------

// File: rtl/icache_prefetch_gen.sv
//------------------------------------------------------------------------------
// Module : icache_prefetch_gen
// Brief  : Next-line instruction prefetch generator with page-bounded
//          sequential line requests buffered in a small FIFO.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package icache_prefetch_gen_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  field0;
        logic [4:0]  field1;
    } pc_req_t;
endpackage

module icache_prefetch_gen
    import icache_prefetch_gen_pkg::*;
#(
    parameter int LINE_OFFSET = 6,
    parameter int PF_DEPTH    = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    upstream_rxreq_vld,
    input  logic    upstream_rxreq_rdy,
    input  pc_req_t upstream_rxreq_pld,
    input  logic    pf_enable,
    input  logic    pf_flush,
    output logic    prefetch_req_vld,
    input  logic    prefetch_req_rdy,
    output pc_req_t prefetch_req_pld
);

    localparam int LW  = 32 - LINE_OFFSET;
    localparam int PLO = 12 - LINE_OFFSET;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int RW  = $clog2(PF_DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [LW-1:0]   r_next_line, w_next_line_nxt;
    logic [RW-1:0]   r_remaining, w_remaining_nxt;
    logic [19:0]     r_page, w_page_nxt;
    logic [4:0]      r_field0, w_field0_nxt;
    logic [4:0]      r_field1, w_field1_nxt;
    logic [LW-1:0]   r_last_line, w_last_line;
    logic            r_last_vld, w_last_vld, w_last_vld_nxt;

    pc_req_t         r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_trigger, w_full, w_page_ok, w_push, w_pop, w_ahead;
    logic [LW-1:0]   w_trig_line, w_dist;
    pc_req_t         w_push_entry;
    logic            w_unused_offset;

    assign w_trig_line     = upstream_rxreq_pld.addr[31:LINE_OFFSET];
    assign w_unused_offset = ^upstream_rxreq_pld.addr[LINE_OFFSET-1:0];
    assign w_trigger       = upstream_rxreq_vld & upstream_rxreq_rdy & pf_enable;
    assign w_full          = (r_count == CW'(FIFO_DEPTH));
    assign w_page_ok       = (r_next_line[LW-1:PLO] == r_page);
    assign w_push          = (r_state == GEN) & pf_enable & w_page_ok & ~w_full & ~pf_flush;
    assign w_pop           = prefetch_req_vld & prefetch_req_rdy & ~pf_flush;

    // A same-cycle push is visible to the trigger's distance calculation.
    assign w_last_line = w_push ? r_next_line : r_last_line;
    assign w_last_vld  = w_push | r_last_vld;
    assign w_dist      = w_last_line - w_trig_line;
    assign w_ahead     = w_last_vld && (w_dist != '0) && (w_dist <= LW'(PF_DEPTH));

    assign w_push_entry.addr   = {r_next_line, {LINE_OFFSET{1'b0}}};
    assign w_push_entry.field0 = r_field0;
    assign w_push_entry.field1 = r_field1;

    always_comb begin
        w_state_nxt     = r_state;
        w_next_line_nxt = r_next_line;
        w_remaining_nxt = r_remaining;
        w_page_nxt      = r_page;
        w_field0_nxt    = r_field0;
        w_field1_nxt    = r_field1;
        w_last_vld_nxt  = r_last_vld;
        if (pf_flush) begin
            w_state_nxt     = IDLE;
            w_remaining_nxt = '0;
            w_last_vld_nxt  = 1'b0;
        end else begin
            if (r_state == GEN) begin
                if (!pf_enable || !w_page_ok) begin
                    w_state_nxt     = IDLE;
                    w_remaining_nxt = '0;
                end else if (w_push) begin
                    w_next_line_nxt = r_next_line + LW'(1);
                    w_remaining_nxt = r_remaining - RW'(1);
                    w_last_vld_nxt  = 1'b1;
                    if (r_remaining == RW'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            if (w_trigger) begin
                if (w_ahead) begin
                    w_next_line_nxt = w_last_line + LW'(1);
                    w_remaining_nxt = RW'(PF_DEPTH) - RW'(w_dist);
                end else begin
                    w_next_line_nxt = w_trig_line + LW'(1);
                    w_remaining_nxt = RW'(PF_DEPTH);
                end
                w_page_nxt   = upstream_rxreq_pld.addr[31:12];
                w_field0_nxt = upstream_rxreq_pld.field0;
                w_field1_nxt = upstream_rxreq_pld.field1;
                w_state_nxt  = (w_remaining_nxt == '0) ? IDLE : GEN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_next_line <= '0;
            r_remaining <= '0;
            r_page      <= '0;
            r_field0    <= '0;
            r_field1    <= '0;
            r_last_line <= '0;
            r_last_vld  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_next_line <= w_next_line_nxt;
            r_remaining <= w_remaining_nxt;
            r_page      <= w_page_nxt;
            r_field0    <= w_field0_nxt;
            r_field1    <= w_field1_nxt;
            r_last_line <= pf_flush ? r_last_line : w_last_line;
            r_last_vld  <= w_last_vld_nxt;
        end
    end

    // Full is taken from the registered count, so a same-cycle pop never frees a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (pf_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_entry;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign prefetch_req_vld = (r_count != '0);
    assign prefetch_req_pld = r_mem[r_rd_ptr];

endmodule

`default_nettype wire
